// File: rtl/flag_unit.sv
// Registered Z/N/C/V status flags with per-flag update mask, direct write,
// and a small LIFO flag stack for interrupt save/restore.
module flag_unit #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] result,
    input  logic             alu_carry,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic             op_sub,
    input  logic             update_en,
    input  logic [3:0]       update_mask,
    input  logic             flags_wr,
    input  logic [3:0]       flags_wdata,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
    output logic [3:0]       flags,
    output logic             zero_comb,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             stack_err
);
    localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW  = $clog2(STACK_DEPTH);
    localparam logic [SPW-1:0] SpFull = SPW'(STACK_DEPTH);

    logic [3:0]     r_flags;
    logic [SPW-1:0] r_sp;
    logic           r_err;
    logic [3:0]     r_mem [STACK_DEPTH];

    logic           w_z;
    logic           w_n;
    logic           w_v;
    logic [3:0]     w_comp;
    logic           w_empty;
    logic           w_full;
    logic           w_push_ok;
    logic           w_pop_ok;
    logic           w_err;
    logic [IW-1:0]  w_wr_idx;
    logic [IW-1:0]  w_top_idx;
    logic [3:0]     w_flags_d;

    assign w_z    = (result == '0);
    assign w_n    = result[WIDTH-1];
    assign w_v    = op_sub ? ((a_msb != b_msb) & (w_n != a_msb))
                           : ((a_msb == b_msb) & (w_n != a_msb));
    assign w_comp = {w_z, w_n, alu_carry, w_v};

    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == SpFull);
    assign w_push_ok = push & ~pop & ~w_full;
    assign w_pop_ok  = pop & ~push & ~w_empty;
    assign w_err     = (push & pop) | (push & w_full) | (pop & w_empty);

    // STACK_DEPTH is a power of two, so the low bits of sp wrap correctly at full.
    assign w_wr_idx  = r_sp[IW-1:0];
    assign w_top_idx = r_sp[IW-1:0] - IW'(1);

    always_comb begin
        w_flags_d = r_flags;
        if (w_pop_ok) begin
            w_flags_d = r_mem[w_top_idx];
        end else if (flags_wr) begin
            w_flags_d = flags_wdata;
        end else if (update_en) begin
            w_flags_d = (update_mask & w_comp) | (~update_mask & r_flags);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 4'b0000;
            r_sp    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_flags <= w_flags_d;
            if (w_push_ok) begin
                r_sp <= r_sp + SPW'(1);
            end else if (w_pop_ok) begin
                r_sp <= r_sp - SPW'(1);
            end
            if (w_err) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // Stack contents are don't-care after reset; only sp is cleared.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[w_wr_idx] <= r_flags;
        end
    end

    assign flags       = r_flags;
    assign zero_comb   = w_z;
    assign stack_empty = w_empty;
    assign stack_full  = w_full;
    assign stack_err   = r_err;
endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_flag_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] result16 = '0;
    logic [7:0]  result8 = '0;
    logic [31:0] result32 = '0;
    logic        alu_carry = 1'b0, a_msb = 1'b0, b_msb = 1'b0, op_sub = 1'b0;
    logic        update_en = 1'b0, flags_wr = 1'b0, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
    logic [3:0]  update_mask = '0, flags_wdata = '0;

    logic [3:0]  flags16, flags8, flags32;
    logic        zc16, zc8, zc32, emp16, emp8, emp32, full16, full8, full32;
    logic        err16, err8, err32;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] m_flags;
    logic [3:0] m_stack[$];
    logic       m_err;

    always #5 clk = ~clk;

    flag_unit #(.WIDTH(16), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .result(result16), .alu_carry(alu_carry), .a_msb(a_msb),
        .b_msb(b_msb), .op_sub(op_sub), .update_en(update_en), .update_mask(update_mask),
        .flags_wr(flags_wr), .flags_wdata(flags_wdata), .push(push), .pop(pop),
        .err_clr(err_clr), .flags(flags16), .zero_comb(zc16), .stack_empty(emp16),
        .stack_full(full16), .stack_err(err16)
    );

    flag_unit #(.WIDTH(8), .STACK_DEPTH(DEPTH)) dut8 (
        .clk(clk), .rst(rst), .result(result8), .alu_carry(alu_carry), .a_msb(a_msb),
        .b_msb(b_msb), .op_sub(op_sub), .update_en(update_en), .update_mask(update_mask),
        .flags_wr(flags_wr), .flags_wdata(flags_wdata), .push(push), .pop(pop),
        .err_clr(err_clr), .flags(flags8), .zero_comb(zc8), .stack_empty(emp8),
        .stack_full(full8), .stack_err(err8)
    );

    flag_unit #(.WIDTH(32), .STACK_DEPTH(DEPTH)) dut32 (
        .clk(clk), .rst(rst), .result(result32), .alu_carry(alu_carry), .a_msb(a_msb),
        .b_msb(b_msb), .op_sub(op_sub), .update_en(update_en), .update_mask(update_mask),
        .flags_wr(flags_wr), .flags_wdata(flags_wdata), .push(push), .pop(pop),
        .err_clr(err_clr), .flags(flags32), .zero_comb(zc32), .stack_empty(emp32),
        .stack_full(full32), .stack_err(err32)
    );

    // Reference flags: subtraction is treated as addition of the negated B operand.
    function automatic logic [3:0] ref_flags(input longint unsigned res, input int w,
                                             input logic c, input logic a, input logic b,
                                             input logic sub);
        longint unsigned half;
        logic z, n, beff, v;
        half = 64'd1 << (w - 1);
        z    = (res == 0);
        n    = (res >= half);
        beff = sub ? ~b : b;
        v    = (a == beff) && (n != a);
        return {z, n, c, v};
    endfunction

    task automatic model_reset();
        m_flags = 4'b0000;
        m_stack.delete();
        m_err   = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] comp, nf;
        logic       e, popped;
        comp   = ref_flags(longint'(result16), 16, alu_carry, a_msb, b_msb, op_sub);
        nf     = m_flags;
        e      = 1'b0;
        popped = 1'b0;
        if (push && pop) e = 1'b1;
        else if (push) begin
            if (m_stack.size() == DEPTH) e = 1'b1;
            else m_stack.push_back(m_flags);
        end else if (pop) begin
            if (m_stack.size() == 0) e = 1'b1;
            else begin
                nf     = m_stack.pop_back();
                popped = 1'b1;
            end
        end
        if (!popped) begin
            if (flags_wr) nf = flags_wdata;
            else if (update_en)
                for (int i = 0; i < 4; i++) if (update_mask[i]) nf[i] = comp[i];
        end
        if (e) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        m_flags = nf;
    endtask

    task automatic idle();
        update_en = 1'b0; update_mask = '0; flags_wr = 1'b0; flags_wdata = '0;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        update_en = 1'b1; update_mask = 4'b1111; result16 = 16'h8000;
        #2 rst = 1'b1;
        #1;
        n_tests++; if (flags16 !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", flags16); end
        @(posedge clk); #1;
        model_reset();
        n_tests++; if (flags16 !== 4'b0000) begin n_fail++; $display("FAIL reset_hold got %b want 0000", flags16); end
        n_tests++; if ({emp16, full16, err16} !== 3'b100) begin n_fail++; $display("FAIL reset_stack got %b want 100", {emp16, full16, err16}); end
        result16 = 16'h0000; #1;
        n_tests++; if (zc16 !== 1'b1) begin n_fail++; $display("FAIL zero_comb_0 got %b want 1", zc16); end
        result16 = 16'h0001; #1;
        n_tests++; if (zc16 !== 1'b0) begin n_fail++; $display("FAIL zero_comb_1 got %b want 0", zc16); end
        @(negedge clk);
        rst = 1'b0;
        idle();
    endtask

    task automatic test_add_sub();
        result16 = 16'h8000; a_msb = 1'b0; b_msb = 1'b0; op_sub = 1'b0; alu_carry = 1'b0;
        update_en = 1'b1; update_mask = 4'b1111;
        tick();
        n_tests++; if (flags16 !== 4'b0101) begin n_fail++; $display("FAIL add_ovf got %b want 0101", flags16); end
        result16 = 16'h7FFF; a_msb = 1'b1; b_msb = 1'b0; op_sub = 1'b1; alu_carry = 1'b1;
        update_en = 1'b1; update_mask = 4'b1111;
        tick();
        n_tests++; if (flags16 !== 4'b0011) begin n_fail++; $display("FAIL sub_ovf got %b want 0011", flags16); end
    endtask

    task automatic test_masked();
        flags_wr = 1'b1; flags_wdata = 4'b1111;
        tick();
        result16 = 16'h0001; alu_carry = 1'b0; a_msb = 1'b0; b_msb = 1'b0; op_sub = 1'b0;
        update_en = 1'b1; update_mask = 4'b0010;
        tick();
        n_tests++; if (flags16 !== 4'b1101) begin n_fail++; $display("FAIL masked_c got %b want 1101", flags16); end
        update_en = 1'b1; update_mask = 4'b1111;
        tick();
        update_en = 1'b1; update_mask = 4'b0000; result16 = 16'h8000;
        tick();
        n_tests++; if (flags16 !== 4'b0000) begin n_fail++; $display("FAIL mask_zero got %b want 0000", flags16); end
        update_en = 1'b1; update_mask = 4'b1111; flags_wr = 1'b1; flags_wdata = 4'b0011;
        tick();
        n_tests++; if (flags16 !== 4'b0011) begin n_fail++; $display("FAIL wr_priority got %b want 0011", flags16); end
    endtask

    task automatic test_stack_fill();
        logic [3:0] vals [4];
        vals[0] = 4'b0001; vals[1] = 4'b0010; vals[2] = 4'b0100; vals[3] = 4'b1000;
        flags_wr = 1'b1; flags_wdata = vals[0];
        tick();
        for (int i = 1; i < 4; i++) begin
            push = 1'b1; flags_wr = 1'b1; flags_wdata = vals[i];
            tick();
        end
        push = 1'b1;
        tick();
        n_tests++; if ({full16, emp16, err16} !== 3'b100) begin n_fail++; $display("FAIL fill_full got %b want 100", {full16, emp16, err16}); end
        push = 1'b1;
        tick();
        n_tests++; if ({err16, full16, flags16} !== 6'b111000) begin n_fail++; $display("FAIL overflow got %b want 111000", {err16, full16, flags16}); end
        for (int i = 3; i >= 0; i--) begin
            pop = 1'b1;
            tick();
            n_tests++; if (flags16 !== vals[i]) begin n_fail++; $display("FAIL pop_%0d got %b want %b", i, flags16, vals[i]); end
        end
        n_tests++; if (emp16 !== 1'b1) begin n_fail++; $display("FAIL drained_empty got %b want 1", emp16); end
        pop = 1'b1;
        tick();
        n_tests++; if ({flags16, emp16, err16} !== 6'b000111) begin n_fail++; $display("FAIL underflow got %b want 000111", {flags16, emp16, err16}); end
        err_clr = 1'b1;
        tick();
        n_tests++; if (err16 !== 1'b0) begin n_fail++; $display("FAIL err_clr1 got %b want 0", err16); end
    endtask

    task automatic test_back_to_back();
        flags_wr = 1'b1; flags_wdata = 4'b1010;
        tick();
        push = 1'b1; update_en = 1'b1; update_mask = 4'b1111;
        result16 = 16'h8000; a_msb = 1'b0; b_msb = 1'b0; op_sub = 1'b0; alu_carry = 1'b0;
        tick();
        n_tests++; if ({flags16, emp16} !== 5'b01010) begin n_fail++; $display("FAIL push_upd got %b want 01010", {flags16, emp16}); end
        pop = 1'b1;
        tick();
        n_tests++; if ({flags16, emp16} !== 5'b10101) begin n_fail++; $display("FAIL pop_restore got %b want 10101", {flags16, emp16}); end
        push = 1'b1; pop = 1'b1; flags_wr = 1'b1; flags_wdata = 4'b0110;
        tick();
        n_tests++; if ({flags16, emp16, err16} !== 6'b011011) begin n_fail++; $display("FAIL push_pop got %b want 011011", {flags16, emp16, err16}); end
        push = 1'b1; pop = 1'b1; err_clr = 1'b1;
        tick();
        n_tests++; if (err16 !== 1'b1) begin n_fail++; $display("FAIL err_new_wins got %b want 1", err16); end
        err_clr = 1'b1;
        tick();
        n_tests++; if (err16 !== 1'b0) begin n_fail++; $display("FAIL err_clr2 got %b want 0", err16); end
    endtask

    task automatic test_width();
        result8 = 8'h80; result32 = 32'h8000_0000;
        a_msb = 1'b0; b_msb = 1'b0; op_sub = 1'b0; alu_carry = 1'b0;
        update_en = 1'b1; update_mask = 4'b1111;
        #1;
        n_tests++; if ({zc8, zc32} !== 2'b00) begin n_fail++; $display("FAIL width_zc_nz got %b want 00", {zc8, zc32}); end
        tick();
        n_tests++; if ({flags8, flags32} !== 8'b0101_0101) begin n_fail++; $display("FAIL width_msb got %b want 01010101", {flags8, flags32}); end
        result8 = 8'h00; result32 = 32'h0;
        update_en = 1'b1; update_mask = 4'b1111;
        #1;
        n_tests++; if ({zc8, zc32} !== 2'b11) begin n_fail++; $display("FAIL width_zc_z got %b want 11", {zc8, zc32}); end
        tick();
        n_tests++; if ({flags8, flags32} !== 8'b1000_1000) begin n_fail++; $display("FAIL width_zero got %b want 10001000", {flags8, flags32}); end
        // Reset in the middle of a cycle with two entries stacked.
        flags_wr = 1'b1; flags_wdata = 4'b0111; push = 1'b1;
        tick();
        push = 1'b1;
        tick();
        n_tests++; if (emp16 !== 1'b0) begin n_fail++; $display("FAIL mid_sp2 got empty %b want 0", emp16); end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_tests++; if ({flags16, emp16, full16, err16} !== 7'b0000100) begin n_fail++; $display("FAIL mid_reset got %b want 0000100", {flags16, emp16, full16, err16}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            result16    = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            alu_carry   = 1'($urandom);
            a_msb       = 1'($urandom);
            b_msb       = 1'($urandom);
            op_sub      = 1'($urandom);
            update_en   = 1'($urandom);
            update_mask = 4'($urandom);
            flags_wr    = ($urandom_range(0, 7) == 0);
            flags_wdata = 4'($urandom);
            push        = ($urandom_range(0, 3) == 0);
            pop         = ($urandom_range(0, 3) == 0);
            err_clr     = ($urandom_range(0, 7) == 0);
            #1;
            n_tests++; if (zc16 !== (result16 == 16'h0)) begin n_fail++; $display("FAIL rnd_zc[%0d] got %b res %h", i, zc16, result16); end
            tick();
            n_tests++; if (flags16 !== m_flags) begin n_fail++; $display("FAIL rnd_flags[%0d] got %b want %b", i, flags16, m_flags); end
            n_tests++; if ({emp16, full16} !== {m_stack.size() == 0, m_stack.size() == DEPTH}) begin
                n_fail++; $display("FAIL rnd_stack[%0d] got %b want depth %0d", i, {emp16, full16}, m_stack.size());
            end
            n_tests++; if (err16 !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d] got %b want %b", i, err16, m_err); end
        end
    endtask

    initial begin
        model_reset();
        idle();
        test_reset();
        test_add_sub();
        test_masked();
        test_stack_fill();
        test_back_to_back();
        test_width();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
